// File: rtl/mt_decode_stage_pkg.sv
// Shared decode encodings for the barrel-threaded RV32I core: opcodes,
// immediate formats, result-select codes and ALU operations.
package mt_decode_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_t;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  // alt selects SUB/SRA; callers gate it so ADDI never becomes a subtract.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Main decoder: opcode/funct fields to datapath controls, flags unsupported opcodes.
module control_unit
  import mt_decode_stage_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic       reg_write,
  output logic       mem_write,
  output logic       jump,
  output logic       branch,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic       adder_src,
  output logic [1:0] res_src,
  output logic [3:0] alu_control,
  output imm_type_t  imm_type,
  output logic       illegal
);

  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    adder_src   = 1'b0;
    res_src     = RES_ALU;
    alu_control = ALU_ADD;
    imm_type    = IMM_I;
    illegal     = 1'b0;
    case (opcode)
      OP_LUI:    begin reg_write = 1'b1; alu_src_b = 1'b1; imm_type = IMM_U; alu_control = ALU_PASS; end
      OP_AUIPC:  begin reg_write = 1'b1; alu_src_a = 1'b1; alu_src_b = 1'b1; imm_type = IMM_U; end
      OP_JAL:    begin reg_write = 1'b1; jump = 1'b1; res_src = RES_PC4; imm_type = IMM_J; end
      OP_JALR:   begin reg_write = 1'b1; jump = 1'b1; adder_src = 1'b1; res_src = RES_PC4; end
      OP_BRANCH: begin branch = 1'b1; imm_type = IMM_B; alu_control = ALU_SUB; end
      OP_LOAD:   begin reg_write = 1'b1; alu_src_b = 1'b1; res_src = RES_MEM; end
      OP_STORE:  begin mem_write = 1'b1; alu_src_b = 1'b1; imm_type = IMM_S; end
      OP_IMM:    begin
        reg_write   = 1'b1;
        alu_src_b   = 1'b1;
        alu_control = alu_op(funct3, funct7b5 & (funct3 == 3'b101));
      end
      OP_OP:     begin reg_write = 1'b1; alu_control = alu_op(funct3, funct7b5); end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext.sv
// Immediate extraction and sign extension for the five RV32I formats.
module imm_ext
  import mt_decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:7]           instr,
  input  imm_type_t             imm_type,
  output logic [DATA_WIDTH-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    case (imm_type)
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  assign imm = DATA_WIDTH'(imm32);

endmodule

// File: rtl/mt_decode_stage_bypass.sv
// Same-cycle writeback forwarding for one source operand of the decoding thread.
module decode_bypass #(
  parameter int DATA_WIDTH   = 32,
  parameter int BITS_THREADS = 3
) (
  input  logic                    reg_write_w,
  input  logic [4:0]              rd_w,
  input  logic [BITS_THREADS-1:0] tid_w,
  input  logic [DATA_WIDTH-1:0]   result_w,
  input  logic [BITS_THREADS-1:0] tid,
  input  logic [4:0]              rs,
  input  logic [DATA_WIDTH-1:0]   rf_data,
  output logic [DATA_WIDTH-1:0]   data
);

  logic hit;

  assign hit  = reg_write_w && (tid_w == tid) && (rd_w == rs) && (rd_w != 5'd0);
  assign data = (rs == 5'd0) ? '0 : (hit ? result_w : rf_data);

endmodule

// File: rtl/mt_reg_file.sv
// Per-thread 32-entry register file: edge write, combinational read, x0 reads zero.
module mt_reg_file #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_THREADS  = 8,
  parameter int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [BITS_THREADS-1:0] tid_w,
  input  logic [4:0]              rd_w,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [BITS_THREADS-1:0] tid_r,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  output logic [DATA_WIDTH-1:0]   rdata1,
  output logic [DATA_WIDTH-1:0]   rdata2
);

  logic [DATA_WIDTH-1:0] regs [NUM_THREADS][32];

  always_ff @(posedge clk) begin
    if (we && rd_w != 5'd0) regs[tid_w][rd_w] <= wdata;
  end

  assign rdata1 = (rs1 == 5'd0) ? '0 : regs[tid_r][rs1];
  assign rdata2 = (rs2 == 5'd0) ? '0 : regs[tid_r][rs2];

endmodule

// File: rtl/mt_decode_stage.sv
// Registered ID/EX decode stage with valid/stall handshake, writeback bypass,
// held-operand refresh, per-thread flush and per-thread halt on trap.
module mt_decode_stage
  import mt_decode_stage_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_THREADS   = 8,
  parameter int BITS_THREADS  = $clog2(NUM_THREADS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_f,
  input  logic [DATA_WIDTH-1:0]    instr_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  input  logic [BITS_THREADS-1:0]  tid_f,
  output logic                     ready_d,
  input  logic                     reg_write_w,
  input  logic [4:0]               rd_w,
  input  logic [DATA_WIDTH-1:0]    result_w,
  input  logic [BITS_THREADS-1:0]  tid_w,
  input  logic                     stall_e,
  input  logic                     flush_e,
  input  logic [BITS_THREADS-1:0]  flush_tid,
  input  logic [NUM_THREADS-1:0]   resume,
  output logic                     valid_d,
  output logic                     reg_write_d,
  output logic                     mem_write_d,
  output logic                     jump_d,
  output logic                     branch_d,
  output logic                     alu_src_a_d,
  output logic                     alu_src_b_d,
  output logic                     adder_src_d,
  output logic [1:0]               res_src_d,
  output logic [3:0]               alu_control_d,
  output logic [2:0]               funct3_d,
  output logic [DATA_WIDTH-1:0]    rd1_d,
  output logic [DATA_WIDTH-1:0]    rd2_d,
  output logic [DATA_WIDTH-1:0]    imm_val_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic [4:0]               rs1_d,
  output logic [4:0]               rs2_d,
  output logic [4:0]               rd_d,
  output logic [BITS_THREADS-1:0]  tid_d,
  output logic                     trap_d,
  output logic [NUM_THREADS-1:0]   halted
);

  // Handshake: the output register advances when it is empty or execute is not
  // stalling (ready_d); a fetch transfers when valid_f and ready_d are both high.
  // Halted threads and the thread being flushed are silently dropped.
  logic [4:0] rs1, rs2, rd;
  logic reg_write, mem_write, jump, branch, alu_src_a, alu_src_b, adder_src, illegal;
  logic [1:0] res_src;
  logic [3:0] alu_control;
  imm_type_t imm_type;
  logic [DATA_WIDTH-1:0] imm, rf1, rf2, op1, op2;
  logic accept, flush_d;
  logic [NUM_THREADS-1:0] halt_set;

  assign rs1 = instr_f[19:15];
  assign rs2 = instr_f[24:20];
  assign rd  = instr_f[11:7];

  control_unit u_ctrl (
    .opcode(instr_f[6:0]), .funct3(instr_f[14:12]), .funct7b5(instr_f[30]),
    .reg_write, .mem_write, .jump, .branch, .alu_src_a, .alu_src_b, .adder_src,
    .res_src, .alu_control, .imm_type, .illegal
  );

  imm_ext #(.DATA_WIDTH(DATA_WIDTH)) u_imm (
    .instr(instr_f[31:7]), .imm_type, .imm
  );

  mt_reg_file #(.DATA_WIDTH(DATA_WIDTH), .NUM_THREADS(NUM_THREADS), .BITS_THREADS(BITS_THREADS)) u_rf (
    .clk, .we(reg_write_w), .tid_w, .rd_w, .wdata(result_w),
    .tid_r(tid_f), .rs1, .rs2, .rdata1(rf1), .rdata2(rf2)
  );

  decode_bypass #(.DATA_WIDTH(DATA_WIDTH), .BITS_THREADS(BITS_THREADS)) u_byp1 (
    .reg_write_w, .rd_w, .tid_w, .result_w, .tid(tid_f), .rs(rs1), .rf_data(rf1), .data(op1)
  );

  decode_bypass #(.DATA_WIDTH(DATA_WIDTH), .BITS_THREADS(BITS_THREADS)) u_byp2 (
    .reg_write_w, .rd_w, .tid_w, .result_w, .tid(tid_f), .rs(rs2), .rf_data(rf2), .data(op2)
  );

  assign ready_d  = !valid_d || !stall_e;
  assign accept   = valid_f && ready_d && !halted[tid_f] && !(flush_e && flush_tid == tid_f);
  assign flush_d  = flush_e && flush_tid == tid_d && valid_d;
  assign halt_set = (accept && illegal) ? (NUM_THREADS'(1) << tid_f) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_d <= 1'b0; reg_write_d <= 1'b0; mem_write_d <= 1'b0; jump_d <= 1'b0;
      branch_d <= 1'b0; alu_src_a_d <= 1'b0; alu_src_b_d <= 1'b0; adder_src_d <= 1'b0;
      res_src_d <= '0; alu_control_d <= '0; funct3_d <= '0; rd1_d <= '0; rd2_d <= '0;
      imm_val_d <= '0; pc_d <= '0; pc_plus4_d <= '0; rs1_d <= '0; rs2_d <= '0;
      rd_d <= '0; tid_d <= '0; trap_d <= 1'b0; halted <= '0;
    end else begin
      // Set is OR-ed after the resume mask so a same-edge trap keeps its thread halted.
      halted <= (halted & ~resume) | halt_set;
      if (ready_d) begin
        valid_d <= accept;
        if (accept) begin
          reg_write_d   <= reg_write & !illegal;
          mem_write_d   <= mem_write & !illegal;
          jump_d        <= jump & !illegal;
          branch_d      <= branch & !illegal;
          alu_src_a_d   <= alu_src_a;
          alu_src_b_d   <= alu_src_b;
          adder_src_d   <= adder_src;
          res_src_d     <= res_src;
          alu_control_d <= alu_control;
          funct3_d      <= instr_f[14:12];
          rd1_d         <= op1;
          rd2_d         <= op2;
          imm_val_d     <= imm;
          pc_d          <= pc_f;
          pc_plus4_d    <= pc_plus4_f;
          rs1_d         <= rs1;
          rs2_d         <= rs2;
          rd_d          <= rd;
          tid_d         <= tid_f;
          trap_d        <= illegal;
        end
      end else if (flush_d) begin
        valid_d <= 1'b0;
      end else if (reg_write_w && tid_w == tid_d && rd_w != 5'd0) begin
        // Held operands track writebacks so execute never consumes a stale value.
        if (rd_w == rs1_d) rd1_d <= result_w;
        if (rd_w == rs2_d) rd2_d <= result_w;
      end
    end
  end

endmodule
